mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store sequencer placed directly upstream of data_memory (word-wide, 8-bit word address).
//  Turns byte/halfword/word load-store requests into word accesses, with read-modify-write for sub-word stores.
//  Sign/zero-extends load data and returns it to the pipeline over a valid/ready handshake.
//  Big-endian: byte offset 0 = bits[31:24], halfword offset 0 = bits[31:16].
// PARAMETERS
//  ADDR_W  8   word-address width to data_memory; byte address is ADDR_W+2 bits
//  DATA_W  32  data width; fixed, other values unsupported
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  req_valid    in   1         request present
//  req_ready    out  1         unit can accept; high only in IDLE
//  req_write    in   1         1=store, 0=load
//  req_size     in   2         00=byte, 01=half, 10=word, 11=reserved (treated as word)
//  req_signed   in   1         sign-extend load; ignored for word loads and all stores
//  req_addr     in   ADDR_W+2  byte address
//  req_wdata    in   32        store data, right-justified
//  resp_valid   out  1         one-cycle completion pulse, loads and stores
//  resp_rdata   out  32        extended load data, valid with resp_valid; 0 for stores
//  misalign_err out  1         valid with resp_valid; access was suppressed
//  dm_address   out  ADDR_W    word address = req_addr[ADDR_W+1:2]
//  dm_inData    out  32        write word to data_memory
//  dm_memRead   out  1         read strobe
//  dm_memWrite  out  1         write strobe; memory commits at the rising edge
//  dm_outData   in   32        read word; valid the cycle after dm_memRead
// BEHAVIOUR
//  - Request captured in IDLE on req_valid&req_ready. All request fields are registered; later input changes are ignored.
//  - States: IDLE, RD, RD_DATA, WR, RESP.
//    Word store: IDLE->WR->RESP. Load: IDLE->RD->RD_DATA->RESP. Sub-word store: IDLE->RD->RD_DATA->WR->RESP.
//    Misaligned request: IDLE->RESP.
//  - Strobes are decoded from state: dm_memRead=1 only in RD; dm_memWrite=1 only in WR; each lasts exactly one cycle.
//  - dm_address holds the captured word address from RD through WR. dm_inData is 0 outside WR.
//  - RD_DATA: samples dm_outData.
//    Load: select byte/half at the offset, then extend per req_signed into the response register.
//    Sub-word store: replace the addressed lane with req_wdata[7:0]/[15:0]; other lanes keep the read value.
//  - RESP: resp_valid=1 for one cycle, then IDLE. Worst-case latency from accept to resp_valid: sub-word store = 4 cycles.
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  - Address wrap: none. The top word (ADDR_W all ones) is an ordinary access.
//  - Back-to-back: req_ready=0 from accept until re-entry to IDLE, so no overlap. Next request is accepted in the cycle after RESP.
//  - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, misalign_err=0, all dm_* outputs=0.
//  - Reset mid-operation: the state clears asynchronously, and dm_memWrite/dm_memRead drop immediately.
//    If rst_n falls before the WR edge, no write occurs. The in-flight request is dropped with no response.
// CONFIGURATION
//  MAU_MISALIGN_TRAP_EN defined:
//    misaligned requests make no dm access and go straight to RESP.
//    misalign_err=1, resp_rdata=0.
//  MAU_MISALIGN_TRAP_EN undefined:
//    the low address bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.
//    misalign_err is tied 0.
// TESTING
//  1 sw 0xDEADBEEF @0x004 -> dm_memWrite one cycle, dm_address=1; resp_valid at accept+2.
//    Then lw @0x004 -> resp_rdata=0xDEADBEEF at accept+3.
//  2 sb 0x80 @0x005 over 0xDEADBEEF -> one read, then write 0xDE80BEEF.
//    lb @0x005 -> 0xFFFFFF80; lbu -> 0x00000080.
//  3 Word 1 = 0x1234F00D: lh @0x006 -> 0xFFFFF00D; lhu -> 0x0000F00D.
//    sh 0xABCD @0x004 -> word 0xABCDF00D.
//  4 lw @0x006, macro on -> RESP at accept+1, misalign_err=1, no strobes.
//    Macro off -> reads word 1, misalign_err=0.
//  5 rst_n low during WR of sb @0x008 -> dm_memWrite falls at once; word 2 unchanged.
//    After release, req_ready=1 and the next request completes normally.
//  6 req_valid held high for 2 requests, second to @0x3FC -> second accepted only after the first RESP.
//    Top word 255 accessed with dm_address=0xFF.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ==========================================================================
// mem_access_unit: MEM-stage load/store sequencer in front of data_memory
// (big-endian, RMW for sub-word stores). Option: MAU_MISALIGN_TRAP_EN. Rev 1.0
// ==========================================================================
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_inData,
  output logic              dm_memRead,
  output logic              dm_memWrite,
  input  logic [DATA_W-1:0] dm_outData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t              state_q;
  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_load;
  logic [DATA_W-1:0]   w_merged;

`ifdef MAU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  logic [ADDR_W+1:0] w_align_addr;
  always_comb begin
    w_align_addr = req_addr;
    if (req_size == 2'b01) w_align_addr[0] = 1'b0;
    if (req_size[1])       w_align_addr[1:0] = 2'b00;
  end
`endif

  // Lane 0 is the most significant byte/halfword of the word.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    w_byte = dm_outData[31:24];
      2'd1:    w_byte = dm_outData[23:16];
      2'd2:    w_byte = dm_outData[15:8];
      default: w_byte = dm_outData[7:0];
    endcase
  end

  assign w_half = addr_q[1] ? dm_outData[15:0] : dm_outData[31:16];

  always_comb begin
    case (size_q)
      2'b00:   w_load = {{24{signed_q & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{signed_q & w_half[15]}}, w_half};
      default: w_load = dm_outData;
    endcase
  end

  always_comb begin
    w_merged = dm_outData;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    w_merged[31:24] = wdata_q[7:0];
        2'd1:    w_merged[23:16] = wdata_q[7:0];
        2'd2:    w_merged[15:8]  = wdata_q[7:0];
        default: w_merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) w_merged[15:0]  = wdata_q[15:0];
      else           w_merged[31:16] = wdata_q[15:0];
    end else begin
      w_merged = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
            addr_q   <= req_addr;
            if (w_misalign) begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else if (req_write && req_size[1]) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
`else
            addr_q   <= w_align_addr;
            if (req_write && req_size[1]) state_q <= S_WR;
            else                          state_q <= S_RD;
`endif
          end
        end
        S_RD:      state_q <= S_RD_DATA;
        S_RD_DATA: begin
          if (write_q) begin
            wdata_q <= w_merged;
            state_q <= S_WR;
          end else begin
            rdata_q <= w_load;
            state_q <= S_RESP;
          end
        end
        S_WR:      state_q <= S_RESP;
        S_RESP:    state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_rdata   = rdata_q;
  assign misalign_err = err_q;
  assign dm_memRead   = (state_q == S_RD);
  assign dm_memWrite  = (state_q == S_WR);
  assign dm_address   = ((state_q == S_RD) || (state_q == S_RD_DATA) || (state_q == S_WR))
                        ? addr_q[ADDR_W+1:2] : '0;
  assign dm_inData    = (state_q == S_WR) ? wdata_q : '0;

endmodule
`default_nettype wire
